cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//   Sits directly downstream of the reservation stations and owns the common data bus (CDB).
//   Each producer (alu_reservation_station et al.) raises a request with its result.
//   The arbiter grants one producer per cycle, round-robin, and pulses that producer's accepted line.
//   Registered tag+data drive the CDB that every reservation-station listener consumes.
// PARAMETERS
//   NUM_PRODUCERS  4  number of requesting producers, >=2
//   DATA_WIDTH     4  bitwidth of a data word
//   CDB_TAG_WIDTH  4  bitwidth of a CDB tag; TAG_BASE+NUM_PRODUCERS <= 2**CDB_TAG_WIDTH
//   TAG_BASE       0  tag of producer 0; producer i broadcasts tag TAG_BASE+i
// PORTS
//   clk           in   1                          clock, all state on posedge
//   rst_n         in   1                          asynchronous active-low reset
//   req           in   NUM_PRODUCERS              req[i]: producer i holds a valid result
//   req_data      in   NUM_PRODUCERS*DATA_WIDTH   producer i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   accepted      out  NUM_PRODUCERS              one-hot/zero grant, combinational, same cycle as req
//   cdb_valid     out  1                          registered: CDB carries a result this cycle
//   cdb_tag       out  CDB_TAG_WIDTH              registered tag of broadcast result
//   cdb_data      out  DATA_WIDTH                 registered data of broadcast result
// BEHAVIOUR
//   Reset (rst_n low, async, dominates everything):
//     cdb_valid=0, cdb_tag=0, cdb_data=0, priority pointer ptr=0; accepted forced to 0 while rst_n low.
//   State: ptr (clog2(NUM_PRODUCERS) bits); CDB output registers.
//   Grant (combinational):
//     - search req starting at index ptr, ascending, wrapping at NUM_PRODUCERS-1 -> 0.
//     - first set bit i wins; accepted = one-hot(i); no request -> accepted = 0.
//     - accepted[j]=1 only if req[j]=1; never more than one bit set.
//   Posedge with winner i:
//     cdb_valid<=1, cdb_tag<=TAG_BASE+i (truncated to CDB_TAG_WIDTH), cdb_data<=req_data[i], ptr<=(i+1) mod N.
//   Posedge with no request:
//     cdb_valid<=0; cdb_tag/cdb_data hold last value; ptr holds.
//   Latency:
//     - result visible on CDB exactly 1 cycle after its accepted pulse.
//     - back-to-back grants give a continuous cdb_valid stream, one result per cycle.
//   Handshake:
//     - producer keeps req and data stable until it sees accepted on a posedge; the transfer completes on that edge.
//     - producer may drop req after the edge (the RS drops reserved).
//     - req dropping without accepted is legal and leaves no state.
//     - a producer re-requesting the cycle after its grant is legal; it competes normally under ptr.
//   Fairness:
//     - every continuously requesting producer is granted within NUM_PRODUCERS cycles.
//   Simultaneous events:
//     - a producer may request in the same cycle the CDB broadcasts its own previous result; no special case.
//   Reset mid-broadcast:
//     - outputs clear asynchronously; the in-flight result is lost.
//     - producers still requesting are re-arbitrated from ptr=0 after release.
//   No X propagation: req_data of non-winning producers is ignored.
// TESTING
//   1 reset: cdb_valid=1 and rst_n pulsed low mid-cycle -> cdb_valid/tag/data=0 before next edge, accepted=0 during reset.
//   2 single: req=0100, req_data[2]=4'h5 -> accepted=0100 same cycle; next cycle cdb_valid=1, tag=2, data=5; req drops -> cdb_valid=0 after.
//   3 round-robin: req=1111 held from reset -> accepted sequence 0001,0010,0100,1000,0001; tags 0,1,2,3,0 one cycle later.
//   4 wrap: ptr=2 (after grant to 1), req=0011 -> grant 0, ptr becomes 1; then req=0010 -> grant 1.
//   5 idle: req=0000 for 3 cycles -> cdb_valid=0, tag/data hold, ptr unchanged, accepted=0.
//   6 TAG_BASE=4, N=4, TAG_WIDTH=3: grant producer 3 -> cdb_tag=7. Separately: two alu_reservation_stations on the bus, the second waiting on the first's tag, capture the broadcast data in the cycle after its grant.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin owner of the common data bus: grants one requesting producer per
// cycle and broadcasts its tag and data on registered CDB outputs.
module cdb_arbiter #(
    parameter int NUM_PRODUCERS = 4,
    parameter int DATA_WIDTH    = 4,
    parameter int CDB_TAG_WIDTH = 4,
    parameter int TAG_BASE      = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_PRODUCERS-1:0]            req,
    input  logic [NUM_PRODUCERS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_PRODUCERS-1:0]            accepted,
    output logic                                cdb_valid,
    output logic [CDB_TAG_WIDTH-1:0]            cdb_tag,
    output logic [DATA_WIDTH-1:0]               cdb_data
);

    localparam int PTR_W = (NUM_PRODUCERS > 1) ? $clog2(NUM_PRODUCERS) : 1;

    // Handshake: producer i holds req[i] and its data stable until it sees
    // accepted[i] high at a posedge; the transfer completes on that edge and the
    // result appears on the CDB for exactly the following cycle. Dropping req
    // without a grant is legal and leaves no state behind.

    logic [PTR_W-1:0]         ptr;
    logic [NUM_PRODUCERS-1:0] grant;
    logic                     found;
    logic [PTR_W-1:0]         win_idx;
    logic [DATA_WIDTH-1:0]    win_data;
    int                       idx;

    // Ascending search starting at ptr, wrapping from NUM_PRODUCERS-1 to 0.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_PRODUCERS; k++) begin
            idx = (int'(ptr) + k) % NUM_PRODUCERS;
            if (!found && req[PTR_W'(idx)]) begin
                found   = 1'b1;
                win_idx = PTR_W'(idx);
            end
        end
        if (found) begin
            grant[win_idx] = 1'b1;
        end
    end

    // Only the winner's data is selected, so losers' data never reaches the bus.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_PRODUCERS; i++) begin
            if (grant[i]) begin
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accepted = rst_n ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else if (found) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= CDB_TAG_WIDTH'(TAG_BASE) + CDB_TAG_WIDTH'(win_idx);
            cdb_data  <= win_data;
            ptr       <= (win_idx == PTR_W'(NUM_PRODUCERS - 1)) ? '0 : win_idx + 1'b1;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule
